// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// common mouse command bytes and the frame layout helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_REQ,
    ST_WAIT_DEV,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERR
  } tx_state_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  // Bits shifted after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [9:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer, FILTER_LEN-sample debounce and falling-edge pulse for
// one open-drain PS/2 line. Shared with the mouse receiver.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    // The filtered value only moves after FILTER_LEN consecutive disagreeing samples.
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send inhibit, bit shifting
// on device clock falling edges, acknowledge check and timeout supervision.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int FILTER_LEN  = 8
) (
  input  logic      in_clk,
  input  logic      reset,
  input  logic      wr_en,
  input  logic [7:0] din,
  inout  wire       ps2c,
  inout  wire       ps2d,
  output logic      tx_busy,
  output logic      tx_done_tick,
  output logic      tx_err_tick,
  output tx_state_e state_dbg
);

  localparam int TMAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    edge_q, edge_d;
  logic [9:0]    shift_q, shift_d;
  logic          c_low_q, c_low_d;
  logic          d_low_q, d_low_d;

  logic c_filt, c_fall, d_filt, d_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk_i   (in_clk),
    .reset_i (reset),
    .line_i  (ps2c),
    .filt_o  (c_filt),
    .fall_o  (c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk_i   (in_clk),
    .reset_i (reset),
    .line_i  (ps2d),
    .filt_o  (d_filt),
    .fall_o  (d_fall_unused)
  );

  logic timeout;
  assign timeout = (timer_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    edge_d  = edge_q;
    shift_d = shift_q;
    d_low_d = d_low_q;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        edge_d  = '0;
        if (wr_en) begin
          shift_d = make_frame(din);
          state_d = ST_RTS;
        end
      end
      ST_RTS: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(INHIBIT_CYC - 1)) begin
          timer_d = '0;
          d_low_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(1)) begin
          timer_d = '0;
          state_d = ST_WAIT_DEV;
        end
      end
      ST_WAIT_DEV, ST_SHIFT: begin
        timer_d = timer_q + 1'b1;
        if (c_fall) begin
          // Edges 1..10 present data, parity, then stop (a 1, i.e. release).
          timer_d = '0;
          d_low_d = ~shift_q[0];
          shift_d = {1'b1, shift_q[9:1]};
          edge_d  = edge_q + 4'd1;
          state_d = (edge_q == 4'(FRAME_LEN - 2)) ? ST_ACK : ST_SHIFT;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_ACK: begin
        timer_d = timer_q + 1'b1;
        if (c_fall) begin
          timer_d = '0;
          state_d = d_filt ? ST_ERR : ST_WAIT_IDLE;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_WAIT_IDLE: begin
        timer_d = timer_q + 1'b1;
        if (c_filt && d_filt) begin
          state_d = ST_IDLE;
        end else if (c_fall) begin
          timer_d = '0;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE || state_d == ST_ERR) begin
      d_low_d = 1'b0;
    end
    c_low_d = (state_d == ST_RTS) || (state_d == ST_REQ);
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      c_low_q <= 1'b0;
      d_low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      c_low_q <= c_low_d;
      d_low_q <= d_low_d;
    end
  end

  // Open-drain: only ever pull low or float.
  assign ps2c = c_low_q ? 1'b0 : 1'bz;
  assign ps2d = d_low_q ? 1'b0 : 1'bz;

  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = (state_q == ST_WAIT_IDLE) && c_filt && d_filt;
  assign tx_err_tick  = (state_q == ST_ERR);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of
// the host and the captured bits are scored against a frame model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 500;
  localparam int FLEN    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;

  wire ps2c;
  wire ps2d;
  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  logic      tx_busy, tx_done_tick, tx_err_tick;
  tx_state_e state_dbg;

  ps2_host_tx #(
    .INHIBIT_CYC (INHIBIT),
    .TIMEOUT_CYC (TIMEOUT),
    .FILTER_LEN  (FLEN)
  ) dut (
    .in_clk       (clk),
    .reset        (rst),
    .wr_en        (wr_en),
    .din          (din),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int hold_cnt = 0;
  int low_run = 0;
  bit started = 1'b0;
  bit exp_busy = 1'b0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit 0 first on the wire).
  function automatic logic [10:0] frame_word(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  // Per-cycle compare: busy behaviour, tick exclusivity, host clock-hold length.
  always @(negedge clk) begin
    if (started) begin
      check("busy", tx_busy, exp_busy);
      if (tx_done_tick || tx_err_tick) check("tick_excl", tx_done_tick & tx_err_tick, 0);
      if (tx_done_tick) done_cnt++;
      if (tx_err_tick) err_cnt++;
      if (ps2c === 1'b0 && !dev_c_low) begin
        low_run++;
      end else if (low_run != 0) begin
        hold_cnt++;
        check("hold_len", low_run, INHIBIT + 2);
        low_run = 0;
      end
      if (rst) exp_busy = 1'b0;
      else if (tx_done_tick || tx_err_tick) exp_busy = 1'b0;
      else if (!exp_busy && wr_en) exp_busy = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    wr_en = 1'b1;
    din   = b;
    step(1);
    wr_en = 1'b0;
    din   = 8'($urandom);
  endtask

  // Device: waits for request-to-send, then clocks n_edges pulses (40-cycle period),
  // sampling data while the clock is high and acking before edge 11 if asked.
  task automatic dev_frame(input bit ack, input bit glitch, input int n_edges,
                           output logic [10:0] got);
    int guard;
    got = '1;
    guard = 0;
    while (ps2c !== 1'b0 && guard < 100) begin step(1); guard++; end
    check("dev_saw_rts", guard < 100, 1);
    guard = 0;
    while (ps2c !== 1'b1 && guard < 100) begin step(1); guard++; end
    check("dev_saw_release", guard < 100, 1);
    step(30);
    got[0] = ps2d;
    for (int k = 1; k <= n_edges; k++) begin
      dev_c_low = 1'b1;
      step(20);
      dev_c_low = 1'b0;
      if (glitch && k == 4) begin
        step(3);
        dev_c_low = 1'b1;
        step(2);
        dev_c_low = 1'b0;
        step(5);
      end else begin
        step(10);
      end
      if (k <= 10) got[k] = ps2d;
      if (k == 10 && ack) dev_d_low = 1'b1;
      step(10);
    end
    dev_d_low = 1'b0;
  endtask

  task automatic wait_tick(input int d0, input int e0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < budget) begin step(1); n++; end
  endtask

  task automatic do_frame(input logic [7:0] b, input bit ack, input bit glitch,
                          output logic [10:0] got);
    int d0, e0, h0;
    logic [10:0] exp;
    d0 = done_cnt;
    e0 = err_cnt;
    h0 = hold_cnt;
    exp_q.push_back(frame_word(b));
    send(b);
    fork
      dev_frame(ack, glitch, 11, got);
      begin
        if (glitch) begin
          step(150);
          wr_en = 1'b1;
          din   = 8'hAA;
          step(1);
          wr_en = 1'b0;
        end
      end
    join
    wait_tick(d0, e0, 200);
    step(5);
    exp = exp_q.pop_front();
    check("frame_bits", got, exp);
    check("done_delta", done_cnt - d0, ack ? 1 : 0);
    check("err_delta", err_cnt - e0, ack ? 0 : 1);
    check("hold_delta", hold_cnt - h0, 1);
    check("idle_after", tx_busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] got;
    int d0, e0, n, guard;

    rst = 1'b1;
    step(3);
    rst = 1'b0;
    started = 1'b1;
    check("rst_ps2c", ps2c, 1);
    check("rst_ps2d", ps2d, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_err_tick, 0);
    step(5);

    // Enable streaming: bits 0,0,1,0,1,1,1,1 parity 0.
    do_frame(CMD_ENABLE, 1'b1, 1'b0, got);
    check("f4_literal", got, 11'h5E8);

    // Reset command: parity 1.
    do_frame(CMD_RESET, 1'b1, 1'b0, got);
    check("ff_literal", got, 11'h7FE);

    // Silent device: error exactly TIMEOUT cycles after clock release.
    d0 = done_cnt;
    e0 = err_cnt;
    send(CMD_SET_RATE);
    guard = 0;
    while (ps2c !== 1'b1 && guard < 100) begin step(1); guard++; end
    check("to_release_seen", guard < 100, 1);
    n = 0;
    while (tx_err_tick !== 1'b1 && n < 1000) begin step(1); n++; end
    check("to_latency", n, TIMEOUT);
    step(1);
    check("to_ps2c_rel", ps2c, 1);
    check("to_ps2d_rel", ps2d, 1);
    check("to_err_delta", err_cnt - e0, 1);
    check("to_done_delta", done_cnt - d0, 0);
    step(5);

    // Device withholds acknowledge.
    do_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, got);
    step(5);

    // Glitch on clock and a second write mid-frame are both ignored.
    do_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, got);
    step(5);

    // Reset after edge 5 while data bit d4=0 is driven low.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00);
    dev_frame(1'b1, 1'b0, 5, got);
    check("pre_rst_ps2d", ps2d, 0);
    check("pre_rst_busy", tx_busy, 1);
    rst = 1'b1;
    step(1);
    check("mid_rst_ps2c", ps2c, 1);
    check("mid_rst_ps2d", ps2d, 1);
    rst = 1'b0;
    step(600);
    check("mid_rst_done", done_cnt - d0, 0);
    check("mid_rst_err", err_cnt - e0, 0);

    do_frame(CMD_ENABLE, 1'b1, 1'b0, got);
    check("f4_after_rst", got, 11'h5E8);

    for (int i = 0; i < 4; i++) begin
      step($urandom_range(1, 20));
      do_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, got);
    end

    step(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
